// File: rtl/l3_fill_controller.sv
// Request sequencer in front of an L3 line cache and word-wide RAM: lookup, multi-beat line fill on read miss,
// write-through/no-allocate writes, and saturating hit/miss counters.
module l3_fill_controller #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_SIZE  = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    input  logic                      req_we,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [DATA_WIDTH-1:0]     req_w_data,
    output logic                      req_done,
    output logic [LINE_SIZE*8-1:0]    req_r_data,
    output logic                      busy,
    output logic                      l3_valid,
    output logic                      l3_we,
    output logic [ADDR_WIDTH-1:0]     l3_addr,
    output logic [DATA_WIDTH-1:0]     l3_w_data,
    input  logic [LINE_SIZE*8-1:0]    l3_r_data,
    input  logic                      l3_hit,
    output logic                      fill_en,
    output logic                      fill_mark_valid,
    output logic [ADDR_WIDTH-1:0]     fill_addr,
    output logic [LINE_SIZE*8-1:0]    fill_data,
    output logic                      ram_rd_en,
    output logic                      ram_wr_en,
    output logic [ADDR_WIDTH-1:0]     ram_addr,
    output logic [DATA_WIDTH-1:0]     ram_w_data,
    input  logic [DATA_WIDTH-1:0]     ram_r_data,
    input  logic                      ram_r_valid,
    input  logic                      ram_wr_ack,
    output logic [CNT_WIDTH-1:0]      hit_count,
    output logic [CNT_WIDTH-1:0]      miss_count
);
    localparam int WORDS_PER_LINE = LINE_SIZE * 8 / DATA_WIDTH;
    localparam int LINE_BITS      = LINE_SIZE * 8;
    localparam int WORD_BYTES     = DATA_WIDTH / 8;
    localparam int CW             = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
    localparam int WSH            = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 0;

    typedef enum logic [2:0] {
        IDLE, LOOKUP, FILL_REQ, FILL_WAIT, FILL_COMMIT, WRITE, RESP
    } state_t;

    state_t                  state, state_n;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    we_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [CW-1:0]           word_cnt;
    logic [LINE_BITS-1:0]    buffer;
    logic [ADDR_WIDTH-1:0]   line_base;
    logic [ADDR_WIDTH-1:0]   word_addr;
    logic                    last_word;

    assign line_base = addr_q & ~ADDR_WIDTH'(LINE_SIZE - 1);
    assign word_addr = addr_q & ~ADDR_WIDTH'(WORD_BYTES - 1);
    assign last_word = (word_cnt == CW'(WORDS_PER_LINE - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            word_cnt   <= '0;
            buffer     <= '0;
            req_r_data <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        we_q    <= req_we;
                        wdata_q <= req_w_data;
                    end
                end
                LOOKUP: begin
                    // Writes count as lookups too; counters pin at all-ones.
                    if (l3_hit) begin
                        if (hit_count != '1) hit_count <= hit_count + CNT_WIDTH'(1);
                    end else if (miss_count != '1) begin
                        miss_count <= miss_count + CNT_WIDTH'(1);
                    end
                    if (!we_q) begin
                        if (l3_hit) req_r_data <= l3_r_data;
                        else        word_cnt   <= '0;
                    end
                end
                FILL_WAIT: begin
                    if (ram_r_valid) begin
                        buffer[int'(word_cnt)*DATA_WIDTH +: DATA_WIDTH] <= ram_r_data;
                        if (!last_word) word_cnt <= word_cnt + CW'(1);
                    end
                end
                FILL_COMMIT: req_r_data <= buffer;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_n   = state;
        l3_valid  = 1'b0;
        l3_we     = 1'b0;
        fill_en   = 1'b0;
        ram_rd_en = 1'b0;
        ram_wr_en = 1'b0;
        ram_addr  = '0;
        req_done  = 1'b0;
        case (state)
            IDLE: if (req_valid) state_n = LOOKUP;
            LOOKUP: begin
                l3_valid = 1'b1;
                if (we_q) begin
                    l3_we   = l3_hit;
                    state_n = WRITE;
                end else begin
                    state_n = l3_hit ? RESP : FILL_REQ;
                end
            end
            FILL_REQ: begin
                ram_rd_en = 1'b1;
                ram_addr  = line_base + (ADDR_WIDTH'(word_cnt) << WSH);
                state_n   = FILL_WAIT;
            end
            FILL_WAIT: if (ram_r_valid) state_n = last_word ? FILL_COMMIT : FILL_REQ;
            FILL_COMMIT: begin
                fill_en = 1'b1;
                state_n = RESP;
            end
            WRITE: begin
                ram_wr_en = 1'b1;
                ram_addr  = word_addr;
                if (ram_wr_ack) state_n = RESP;
            end
            RESP: begin
                req_done = 1'b1;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy            = (state != IDLE);
    assign fill_mark_valid = fill_en;
    assign fill_addr       = fill_en ? line_base : '0;
    assign fill_data       = fill_en ? buffer : '0;
    assign l3_addr         = addr_q;
    assign l3_w_data       = wdata_q;
    assign ram_w_data      = wdata_q;

endmodule

// File: tb/tb_l3_fill_controller.sv
// Bench for l3_fill_controller: directed vector table, reset-abort and saturation sequences, then random
// traffic against a transaction-level model of RAM contents, L3 residency and latency.
module tb_l3_fill_controller;
    localparam int W = 4;
    localparam logic [127:0] L100  = 128'hC0DE010C_C0DE0108_C0DE0104_C0DE0100;
    localparam logic [127:0] LA0   = 128'h000000A3_000000A2_000000A1_000000A0;
    localparam logic [127:0] L100W = 128'hC0DE010C_DEADBEEF_C0DE0104_C0DE0100;
    localparam logic [127:0] L300  = 128'hC0DE030C_C0DE0308_12345678_C0DE0300;
    localparam logic [127:0] L100C = 128'hC0DE010C_CAFEF00D_C0DE0104_C0DE0100;

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    logic req_valid, req_we;
    logic [31:0] req_addr, req_w_data;
    logic req_done, busy, l3_valid, l3_we, fill_en, fill_mark_valid, ram_rd_en, ram_wr_en;
    logic [127:0] req_r_data, fill_data, l3_r_data;
    logic [31:0] l3_addr, l3_w_data, fill_addr, ram_addr, ram_w_data, ram_r_data;
    logic l3_hit, ram_r_valid, ram_wr_ack;
    logic [31:0] hit_count, miss_count;

    logic s_req_done, s_busy, s_l3_valid, s_l3_we, s_fill_en, s_fill_mark_valid, s_ram_rd_en, s_ram_wr_en;
    logic [127:0] s_req_r_data, s_fill_data;
    logic [31:0] s_l3_addr, s_l3_w_data, s_fill_addr, s_ram_addr, s_ram_w_data;
    logic [3:0] s_hit_count, s_miss_count;

    l3_fill_controller dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_w_data(req_w_data), .req_done(req_done), .req_r_data(req_r_data), .busy(busy),
        .l3_valid(l3_valid), .l3_we(l3_we), .l3_addr(l3_addr), .l3_w_data(l3_w_data),
        .l3_r_data(l3_r_data), .l3_hit(l3_hit), .fill_en(fill_en), .fill_mark_valid(fill_mark_valid),
        .fill_addr(fill_addr), .fill_data(fill_data), .ram_rd_en(ram_rd_en), .ram_wr_en(ram_wr_en),
        .ram_addr(ram_addr), .ram_w_data(ram_w_data), .ram_r_data(ram_r_data),
        .ram_r_valid(ram_r_valid), .ram_wr_ack(ram_wr_ack), .hit_count(hit_count),
        .miss_count(miss_count)
    );

    // Narrow-counter twin on the same stimulus, used for the saturation checks.
    l3_fill_controller #(.CNT_WIDTH(4)) dut_sat (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_w_data(req_w_data), .req_done(s_req_done), .req_r_data(s_req_r_data), .busy(s_busy),
        .l3_valid(s_l3_valid), .l3_we(s_l3_we), .l3_addr(s_l3_addr), .l3_w_data(s_l3_w_data),
        .l3_r_data(l3_r_data), .l3_hit(l3_hit), .fill_en(s_fill_en), .fill_mark_valid(s_fill_mark_valid),
        .fill_addr(s_fill_addr), .fill_data(s_fill_data), .ram_rd_en(s_ram_rd_en), .ram_wr_en(s_ram_wr_en),
        .ram_addr(s_ram_addr), .ram_w_data(s_ram_w_data), .ram_r_data(ram_r_data),
        .ram_r_valid(ram_r_valid), .ram_wr_ack(ram_wr_ack), .hit_count(s_hit_count),
        .miss_count(s_miss_count)
    );

    // ---------------- environment: L3 line store and RAM ----------------
    logic [255:0]  env_valid;
    logic [127:0]  env_line [256];
    logic [1023:0] ram_wflag = '0;
    logic [31:0]   ram_mem [1024];
    logic [31:0]   pend_addr;
    logic          env_rv;
    logic          inject = 1'b0;
    int            lat_cfg = 1, ack_cfg = 0, rcnt, wcnt;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        if (a[11:4] == 8'h20) return 32'hA0 + 32'(a[3:2]);
        return {16'hC0DE, a[15:0]};
    endfunction

    function automatic logic [31:0] memrd(input logic [31:0] a);
        return ram_wflag[a[11:2]] ? ram_mem[a[11:2]] : dflt(a);
    endfunction

    assign l3_hit      = env_valid[l3_addr[11:4]] && (l3_addr[31:12] == 20'd0);
    assign l3_r_data   = env_line[l3_addr[11:4]];
    assign ram_r_valid = env_rv | inject;
    assign ram_wr_ack  = ram_wr_en && (wcnt >= ack_cfg);

    always @(posedge clk) begin
        if (rst) begin
            env_valid <= '0;
            env_rv    <= 1'b0;
            rcnt      <= 0;
            wcnt      <= 0;
        end else begin
            if (fill_en) begin
                env_valid[fill_addr[11:4]] <= 1'b1;
                env_line[fill_addr[11:4]]  <= fill_data;
            end
            if (l3_we) env_line[l3_addr[11:4]][l3_addr[3:2]*32 +: 32] <= l3_w_data;
            if (ram_wr_en && ram_wr_ack) begin
                ram_mem[ram_addr[11:2]]   <= ram_w_data;
                ram_wflag[ram_addr[11:2]] <= 1'b1;
            end
            wcnt <= ram_wr_en ? wcnt + 1 : 0;
            if (ram_rd_en) begin
                pend_addr  <= ram_addr;
                rcnt       <= lat_cfg - 1;
                env_rv     <= (lat_cfg == 1);
                ram_r_data <= memrd(ram_addr);
            end else if (rcnt > 0) begin
                rcnt       <= rcnt - 1;
                env_rv     <= (rcnt == 1);
                ram_r_data <= memrd(pend_addr);
            end else begin
                env_rv <= 1'b0;
            end
        end
    end

    // ---------------- reference model ----------------
    logic [255:0] ref_present;
    logic [31:0]  ref_mem [logic [31:0]];
    int           ref_hits, ref_misses;
    logic [127:0] ref_last;

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    task automatic ref_reset();
        ref_present = '0;
        ref_hits    = 0;
        ref_misses  = 0;
        ref_last    = '0;
    endtask

    task automatic predict(input logic we, input logic [31:0] addr, wdata, input int lat, ackd,
                           output int cyc, rd, fl, output logic l3we, output logic [127:0] line);
        logic [31:0] base;
        logic hit;
        base = addr & ~32'hF;
        hit  = ref_present[addr[11:4]] && (addr[31:12] == 20'd0);
        if (hit) ref_hits++; else ref_misses++;
        if (!we) begin
            for (int i = 0; i < W; i++) line[i*32 +: 32] = ref_rd(base + 32'(4*i));
            cyc  = hit ? 2 : 3 + W * (1 + lat);
            rd   = hit ? 0 : W;
            fl   = hit ? 0 : 1;
            l3we = 1'b0;
            ref_present[addr[11:4]] = 1'b1;
            ref_last = line;
        end else begin
            ref_mem[addr & ~32'h3] = wdata;
            line = ref_last;
            cyc  = 3 + ackd;
            rd   = 0;
            fl   = 0;
            l3we = hit;
        end
    endtask

    // ---------------- checking ----------------
    int checks = 0, errors = 0, cur_id = 0;

    task automatic chk(input string name, input logic [127:0] act, exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (txn %0d): got %0h expected %0h", name, cur_id, act, exp);
        end
    endtask

    task automatic run_req(input logic we, input logic [31:0] addr, wdata, input int lat, ackd,
                           output int cyc, rd, fl, output logic l3we, output logic [127:0] line, fdata,
                           output logic [31:0] faddr);
        int idle_cycles;
        lat_cfg = lat;
        ack_cfg = ackd;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_w_data = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom; req_w_data = $urandom;
        cyc = 0; rd = 0; fl = 0; l3we = 1'b0; line = '0; fdata = '0; faddr = '0; idle_cycles = 0;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (!busy) idle_cycles++;
            if (l3_valid && l3_we) l3we = 1'b1;
            if (ram_rd_en) begin
                chk("ram_rd_addr", 128'(ram_addr), 128'((addr & ~32'hF) + 32'(rd * 4)));
                rd++;
            end
            if (ram_wr_en) chk("ram_wr_addr_data", 128'({ram_w_data, ram_addr}), 128'({wdata, addr & ~32'h3}));
            if (fill_en) begin
                fl++;
                faddr = fill_addr;
                fdata = fill_data;
                chk("fill_mark_valid", 128'(fill_mark_valid), 128'(1));
            end
            if (req_done) begin
                cyc  = n;
                line = req_r_data;
                break;
            end
        end
        chk("busy_until_done", 128'(idle_cycles), 128'(0));
    endtask

    task automatic do_check(input logic we, input logic [31:0] addr, wdata, input int lat, ackd,
                            input int ecyc, erd, efl, input logic el3we, input logic [127:0] eline);
        int cyc, rd, fl;
        logic l3we;
        logic [127:0] line, fdata;
        logic [31:0] faddr;
        run_req(we, addr, wdata, lat, ackd, cyc, rd, fl, l3we, line, fdata, faddr);
        chk("done_latency", 128'(cyc), 128'(ecyc));
        chk("ram_rd_count", 128'(rd), 128'(erd));
        chk("fill_count", 128'(fl), 128'(efl));
        chk("l3_we", 128'(l3we), 128'(el3we));
        chk("req_r_data", line, eline);
        if (efl != 0) begin
            chk("fill_addr", 128'(faddr), 128'(addr & ~32'hF));
            chk("fill_data", fdata, eline);
        end
        chk("hit_count", 128'(hit_count), 128'(ref_hits));
        chk("miss_count", 128'(miss_count), 128'(ref_misses));
        chk("sat_hit_count", 128'(s_hit_count), 128'(ref_hits > 15 ? 15 : ref_hits));
        chk("sat_miss_count", 128'(s_miss_count), 128'(ref_misses > 15 ? 15 : ref_misses));
        cur_id++;
    endtask

    task automatic do_pred(input logic we, input logic [31:0] addr, wdata, input int lat, ackd);
        int cyc, rd, fl;
        logic l3we;
        logic [127:0] line;
        predict(we, addr, wdata, lat, ackd, cyc, rd, fl, l3we, line);
        do_check(we, addr, wdata, lat, ackd, cyc, rd, fl, l3we, line);
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_ctl"}, 128'({busy, req_done, l3_valid, l3_we, fill_en, fill_mark_valid,
                                   ram_rd_en, ram_wr_en}), 128'(0));
        chk({name, "_req_r_data"}, req_r_data, 128'(0));
        chk({name, "_fill"}, fill_data | 128'(fill_addr), 128'(0));
        chk({name, "_addrs"}, 128'({ram_addr, l3_addr, l3_w_data, ram_w_data}), 128'(0));
        chk({name, "_counts"}, 128'({hit_count, miss_count, s_hit_count, s_miss_count}), 128'(0));
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        int          ackd;
        int          cyc;
        int          rd;
        int          fl;
        logic        l3we;
        logic [127:0] line;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int cyc, rd, fl, nrd, bad;
        logic l3we;
        logic [127:0] line;

        tbl[0] = '{1'b0, 32'h100, 32'h0,        1, 0, 11, 4, 1, 1'b0, L100};
        tbl[1] = '{1'b0, 32'h104, 32'h0,        1, 0,  2, 0, 0, 1'b0, L100};
        tbl[2] = '{1'b0, 32'h200, 32'h0,        3, 0, 19, 4, 1, 1'b0, LA0};
        tbl[3] = '{1'b1, 32'h108, 32'hDEADBEEF, 1, 0,  3, 0, 0, 1'b1, LA0};
        tbl[4] = '{1'b0, 32'h100, 32'h0,        1, 0,  2, 0, 0, 1'b0, L100W};
        tbl[5] = '{1'b1, 32'h304, 32'h12345678, 1, 2,  5, 0, 0, 1'b0, L100W};
        tbl[6] = '{1'b0, 32'h30C, 32'h0,        2, 0, 15, 4, 1, 1'b0, L300};
        tbl[7] = '{1'b1, 32'h10B, 32'hCAFEF00D, 1, 0,  3, 0, 0, 1'b1, L300};
        tbl[8] = '{1'b0, 32'h100, 32'h0,        1, 0,  2, 0, 0, 1'b0, L100C};

        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_w_data = '0;
        ref_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_zero("reset");

        foreach (tbl[i]) begin
            predict(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].lat, tbl[i].ackd, cyc, rd, fl, l3we, line);
            do_check(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].lat, tbl[i].ackd,
                     tbl[i].cyc, tbl[i].rd, tbl[i].fl, tbl[i].l3we, tbl[i].line);
        end

        // Reset during a fill with two words already buffered, then a stray read strobe in IDLE.
        lat_cfg = 3;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h400;
        @(posedge clk); #1;
        req_valid = 1'b0;
        nrd = 0;
        for (int n = 0; n < 100 && nrd < 3; n++) begin
            @(negedge clk);
            if (ram_rd_en) nrd++;
        end
        chk("abort_reached_third_word", 128'(nrd), 128'(3));
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; inject = 1'b1;
        @(negedge clk);
        chk_zero("abort");
        @(posedge clk); #1 inject = 1'b0;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (fill_en || req_done || busy) bad++;
        end
        chk("abort_quiet", 128'(bad), 128'(0));
        ref_reset();
        do_pred(1'b0, 32'h400, 32'h0, 2, 0);

        // Enough cold misses to pin the 4-bit miss counter.
        for (int i = 0; i < 16; i++) do_pred(1'b0, 32'h800 + 32'(i * 16), 32'h0, 1, 0);
        chk("miss_saturated", 128'(s_miss_count), 128'(15));

        for (int i = 0; i < 60; i++)
            do_pred($urandom_range(0, 2) == 0, 32'($urandom_range(0, 32'h3FF)), $urandom,
                    $urandom_range(1, 4), $urandom_range(0, 2));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
